// File: rtl/ysyx_040066_cache_axi_bridge_if.sv
// AXI4 master bus between the cache bridge and the memory-side interconnect.
interface ysyx_040066_cache_axi_bridge_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/ysyx_040066_cache_axi_bridge.sv
// Cache line request to AXI4 burst bridge: one outstanding transaction, writes before reads.
// Cached lines move as LINE_BEATS x 64b INCR bursts; uncached (addr[UC_BIT]==0) as one beat.
module ysyx_040066_cache_axi_bridge #(
  parameter int unsigned UC_BIT     = 31,
  parameter int unsigned LINE_BEATS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                addr,
  input  logic                       rd_req,
  output logic                       rd_ready,
  output logic                       rd_last,
  output logic [63:0]                rd_data,
  output logic                       rd_error,
  input  logic                       wr_req,
  input  logic [LINE_BEATS*64-1:0]   wr_data,
  output logic                       wr_ready,
  output logic                       wr_error,
  ysyx_040066_cache_axi_bridge_if.master axi
);

  localparam int unsigned LINE_W = LINE_BEATS * 64;
  localparam int unsigned CNT_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WRITE,
    S_WRESP
  } state_e;

  state_e              state_q,   state_d;
  logic [31:0]         addr_q,    addr_d;
  logic [CNT_W-1:0]    len_q,     len_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [LINE_W-1:0]   buf_q,     buf_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q,  rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q,  wvalid_d;
  logic                bready_q,  bready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q,  w_done_d;

  logic ar_fire, r_fire, aw_fire, w_fire, b_fire, cnt_last;
  logic unused_resp_lo;

  assign ar_fire  = arvalid_q & axi.arready;
  assign r_fire   = rready_q  & axi.rvalid;
  assign aw_fire  = awvalid_q & axi.awready;
  assign w_fire   = wvalid_q  & axi.wready;
  assign b_fire   = bready_q  & axi.bvalid;
  assign cnt_last = (cnt_q == len_q);

  assign unused_resp_lo = axi.rresp[0] ^ axi.bresp[0];

  // Next-state and next-register computation for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          state_d   = S_WRITE;
          addr_d    = addr;
          len_d     = addr[UC_BIT] ? CNT_W'(LINE_BEATS - 1) : '0;
          buf_d     = wr_data;
          cnt_d     = '0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (rd_req) begin
          state_d   = S_RADDR;
          addr_d    = addr;
          len_d     = addr[UC_BIT] ? CNT_W'(LINE_BEATS - 1) : '0;
          arvalid_d = 1'b1;
        end
      end
      S_RADDR: begin
        if (ar_fire) begin
          state_d   = S_RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
        end
      end
      S_RDATA: begin
        // Completion is decided by the beat counter, not by rlast.
        if (r_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_last) begin
            state_d  = S_IDLE;
            rready_d = 1'b0;
          end
        end
      end
      S_WRITE: begin
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_last) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end
        end
        if ((w_done_q | (w_fire & cnt_last)) & (aw_done_q | aw_fire)) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        if (b_fire) begin
          state_d  = S_IDLE;
          bready_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and control flops take the synchronous reset; address/data holding regs do not.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
    addr_q <= addr_d;
    len_q  <= len_d;
    buf_q  <= buf_d;
  end

  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'(len_q);
  assign axi.arsize  = 3'd3;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'(len_q);
  assign axi.awsize  = 3'd3;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;

  assign axi.wdata   = buf_q[{cnt_q, 6'd0} +: 64];
  assign axi.wstrb   = 8'hFF;
  assign axi.wlast   = cnt_last;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  // Beat strobes pass straight through so the cache sees data in the cycle it arrives.
  assign rd_ready = r_fire;
  assign rd_data  = axi.rdata;
  assign rd_last  = r_fire & cnt_last;
  assign rd_error = r_fire & (axi.rresp[1] | (axi.rlast != cnt_last));
  assign wr_ready = b_fire;
  assign wr_error = b_fire & axi.bresp[1];

endmodule

// File: tb/tb_ysyx_040066_cache_axi_bridge.sv
// Directed bench for the cache AXI bridge: reads, writes, protocol errors, back-to-back, reset.
`timescale 1ns/1ps
module tb_ysyx_040066_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic         rd_req;
  logic         rd_ready;
  logic         rd_last;
  logic [63:0]  rd_data;
  logic         rd_error;
  logic         wr_req;
  logic [511:0] wr_data;
  logic         wr_ready;
  logic         wr_error;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_040066_cache_axi_bridge_if axi();

  ysyx_040066_cache_axi_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .rd_req   (rd_req),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .rd_data  (rd_data),
    .rd_error (rd_error),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .wr_error (wr_error),
    .axi      (axi)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic slave_idle;
    axi.arready = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bresp   = '0;
    axi.bvalid  = 1'b0;
  endtask

  // Runs a complete read with a zero-wait slave and reports what the cache side saw.
  task automatic drive_read(input logic [31:0] a, input int nb, input logic [63:0] base,
                            output int n_rdy, output int last_at, output int n_err,
                            output int n_bad);
    int t;
    int beat;
    addr = a; rd_req = 1'b1; axi.arready = 1'b1;
    t = 0;
    tick;
    while (axi.rready !== 1'b1 && t < 20) begin tick; t++; end
    n_rdy = 0; last_at = -1; n_err = 0; n_bad = 0; beat = 0;
    while (beat < nb && t < 60) begin
      axi.rvalid = 1'b1; axi.rdata = base + 64'(beat); axi.rlast = (beat == nb - 1);
      axi.rresp = 2'b00;
      #1;
      if (rd_ready === 1'b1) n_rdy++;
      if (rd_last === 1'b1 && last_at < 0) last_at = beat;
      if (rd_error !== 1'b0) n_err++;
      if (rd_data !== base + 64'(beat)) n_bad++;
      tick; beat++; t++;
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_req = 1'b0; axi.arready = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;
    slave_idle();
    tick; tick;
    rst = 1'b0;
    axi.rvalid = 1'b1; axi.bvalid = 1'b1;
    #1;
    n_tests++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_valids: got %b expected 00000",
               {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready});
    end
    n_tests++;
    if (rd_ready !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got rd_ready=%b wr_ready=%b expected 0 0", rd_ready, wr_ready);
    end
    slave_idle();
    tick;
  endtask

  task automatic test_cached_read;
    int n_rdy;
    logic exp_last;
    n_rdy = 0;
    addr = 32'h8000_0040; rd_req = 1'b1; axi.arready = 1'b1;
    tick; #1;
    n_tests++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h8000_0040 || axi.arlen !== 8'd7 ||
        axi.arsize !== 3'd3 || axi.arburst !== 2'b01) begin
      n_fail++;
      $display("FAIL cached_ar: got valid=%b addr=%h len=%0d size=%0d burst=%b expected 1 80000040 7 3 01",
               axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst);
    end
    tick; #1;
    n_tests++;
    if (axi.rready !== 1'b1 || axi.arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL cached_rready: got rready=%b arvalid=%b expected 1 0", axi.rready, axi.arvalid);
    end
    for (int i = 0; i < 8; i++) begin
      axi.rvalid = 1'b1; axi.rdata = 64'(i); axi.rlast = (i == 7); axi.rresp = 2'b00;
      exp_last = (i == 7);
      #1;
      if (rd_ready === 1'b1) n_rdy++;
      n_tests++;
      if (rd_data !== 64'(i) || rd_last !== exp_last || rd_error !== 1'b0) begin
        n_fail++;
        $display("FAIL cached_beat%0d: got data=%h last=%b err=%b expected %h %b 0",
                 i, rd_data, rd_last, rd_error, 64'(i), exp_last);
      end
      tick;
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_req = 1'b0; axi.arready = 1'b0;
    #1;
    n_tests++;
    if (n_rdy !== 8 || axi.rready !== 1'b0) begin
      n_fail++;
      $display("FAIL cached_done: got pulses=%0d rready=%b expected 8 0", n_rdy, axi.rready);
    end
    tick; #1;
    n_tests++;
    if (axi.arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL cached_no_reissue: got arvalid=%b expected 0", axi.arvalid);
    end
  endtask

  task automatic test_uncached_read;
    addr = 32'h1000_0000; rd_req = 1'b1; axi.arready = 1'b1;
    tick; #1;
    n_tests++;
    if (axi.arvalid !== 1'b1 || axi.arlen !== 8'd0 || axi.araddr !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL uc_ar: got valid=%b len=%0d addr=%h expected 1 0 10000000",
               axi.arvalid, axi.arlen, axi.araddr);
    end
    tick;
    axi.rvalid = 1'b1; axi.rdata = 64'h0000_0000_CAFE_F00D; axi.rlast = 1'b1; axi.rresp = 2'b10;
    #1;
    n_tests++;
    if (rd_ready !== 1'b1 || rd_last !== 1'b1 || rd_error !== 1'b1 ||
        rd_data !== 64'h0000_0000_CAFE_F00D) begin
      n_fail++;
      $display("FAIL uc_beat: got rdy=%b last=%b err=%b data=%h expected 1 1 1 cafef00d",
               rd_ready, rd_last, rd_error, rd_data);
    end
    tick;
    slave_idle(); rd_req = 1'b0;
    #1;
    n_tests++;
    if (axi.rready !== 1'b0) begin
      n_fail++;
      $display("FAIL uc_done: got rready=%b expected 0", axi.rready);
    end
  endtask

  task automatic test_back_to_back;
    logic [511:0] line;
    int k, aw_cyc, n_aw, n_wrdy, n_bad, t;
    int n_rdy, last_at, n_err, n_dbad;
    for (int i = 0; i < 8; i++) line[64*i +: 64] = 64'(i);
    addr = 32'h8000_1000; wr_data = line; wr_req = 1'b1;
    tick; #1;
    n_tests++;
    if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || axi.awlen !== 8'd7 ||
        axi.awaddr !== 32'h8000_1000) begin
      n_fail++;
      $display("FAIL evict_entry: got awvalid=%b wvalid=%b awlen=%0d awaddr=%h expected 1 1 7 80001000",
               axi.awvalid, axi.wvalid, axi.awlen, axi.awaddr);
    end
    k = 0; aw_cyc = 0; n_aw = 0; n_wrdy = 0; n_bad = 0; t = 0;
    while (axi.bready !== 1'b1 && t < 60) begin
      axi.awready = (aw_cyc >= 3);
      axi.wready  = t[0];
      #1;
      if (wr_ready === 1'b1) n_wrdy++;
      if (axi.awvalid === 1'b1) begin
        aw_cyc++;
        if (axi.awready === 1'b1) n_aw++;
      end
      if (axi.wvalid === 1'b1 && axi.wready === 1'b1) begin
        if (axi.wdata !== 64'(k) || axi.wlast !== (k == 7) || axi.wstrb !== 8'hFF) n_bad++;
        k++;
      end
      tick; t++;
    end
    axi.awready = 1'b0; axi.wready = 1'b0;
    n_tests++;
    if (axi.bready !== 1'b1 || k !== 8 || n_bad !== 0) begin
      n_fail++;
      $display("FAIL evict_wbeats: got bready=%b beats=%0d bad=%0d expected 1 8 0", axi.bready, k, n_bad);
    end
    n_tests++;
    if (n_aw !== 1 || aw_cyc !== 4 || n_wrdy !== 0) begin
      n_fail++;
      $display("FAIL evict_aw: got handshakes=%0d aw_cycles=%0d early_wr_ready=%0d expected 1 4 0",
               n_aw, aw_cyc, n_wrdy);
    end
    #1;
    n_tests++;
    if (wr_ready !== 1'b0 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL evict_wait_b: got wr_ready=%b awvalid=%b wvalid=%b expected 0 0 0",
               wr_ready, axi.awvalid, axi.wvalid);
    end
    tick;
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    #1;
    n_tests++;
    if (wr_ready !== 1'b1 || wr_error !== 1'b0) begin
      n_fail++;
      $display("FAIL evict_b: got wr_ready=%b wr_error=%b expected 1 0", wr_ready, wr_error);
    end
    tick;
    axi.bvalid = 1'b0; wr_req = 1'b0; rd_req = 1'b1; addr = 32'h8000_2000;
    #1;
    n_tests++;
    if (wr_ready !== 1'b0 || axi.bready !== 1'b0 || axi.arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got wr_ready=%b bready=%b arvalid=%b expected 0 0 0",
               wr_ready, axi.bready, axi.arvalid);
    end
    tick; #1;
    n_tests++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h8000_2000 || axi.awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_refill_ar: got arvalid=%b araddr=%h awvalid=%b expected 1 80002000 0",
               axi.arvalid, axi.araddr, axi.awvalid);
    end
    drive_read(32'h8000_2000, 8, 64'h2000, n_rdy, last_at, n_err, n_dbad);
    n_tests++;
    if (n_rdy !== 8 || last_at !== 7 || n_err !== 0 || n_dbad !== 0) begin
      n_fail++;
      $display("FAIL b2b_refill: got pulses=%0d last_at=%0d errs=%0d bad=%0d expected 8 7 0 0",
               n_rdy, last_at, n_err, n_dbad);
    end
  endtask

  task automatic test_uncached_write;
    int n_rdy, last_at, n_err, n_dbad;
    addr = 32'h1000_0008; wr_data = '1; wr_data[63:0] = 64'hDEAD;
    wr_req = 1'b1; rd_req = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    tick; #1;
    n_tests++;
    if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || axi.arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL uw_priority: got awvalid=%b wvalid=%b arvalid=%b expected 1 1 0",
               axi.awvalid, axi.wvalid, axi.arvalid);
    end
    n_tests++;
    if (axi.awaddr !== 32'h1000_0008 || axi.awlen !== 8'd0 || axi.awsize !== 3'd3 ||
        axi.awburst !== 2'b01 || axi.wdata !== 64'hDEAD || axi.wlast !== 1'b1 ||
        axi.wstrb !== 8'hFF) begin
      n_fail++;
      $display("FAIL uw_fields: got addr=%h len=%0d size=%0d burst=%b data=%h last=%b strb=%h expected 10000008 0 3 01 dead 1 ff",
               axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.wdata, axi.wlast, axi.wstrb);
    end
    tick; #1;
    n_tests++;
    if (axi.bready !== 1'b1 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL uw_wresp: got bready=%b awvalid=%b wvalid=%b expected 1 0 0",
               axi.bready, axi.awvalid, axi.wvalid);
    end
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b11;
    #1;
    n_tests++;
    if (wr_ready !== 1'b1 || wr_error !== 1'b1) begin
      n_fail++;
      $display("FAIL uw_b: got wr_ready=%b wr_error=%b expected 1 1", wr_ready, wr_error);
    end
    tick;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; wr_req = 1'b0;
    #1;
    n_tests++;
    if (wr_ready !== 1'b0 || wr_error !== 1'b0) begin
      n_fail++;
      $display("FAIL uw_pulse: got wr_ready=%b wr_error=%b expected 0 0", wr_ready, wr_error);
    end
    tick; #1;
    n_tests++;
    if (axi.arvalid !== 1'b1 || axi.arlen !== 8'd0 || axi.araddr !== 32'h1000_0008) begin
      n_fail++;
      $display("FAIL uw_then_read: got arvalid=%b arlen=%0d araddr=%h expected 1 0 10000008",
               axi.arvalid, axi.arlen, axi.araddr);
    end
    drive_read(32'h1000_0008, 1, 64'h55, n_rdy, last_at, n_err, n_dbad);
    n_tests++;
    if (n_rdy !== 1 || last_at !== 0 || n_err !== 0 || n_dbad !== 0) begin
      n_fail++;
      $display("FAIL uw_read_done: got pulses=%0d last_at=%0d errs=%0d bad=%0d expected 1 0 0 0",
               n_rdy, last_at, n_err, n_dbad);
    end
  endtask

  task automatic test_rlast_mismatch;
    logic exp_err, exp_last;
    addr = 32'h8000_0080; rd_req = 1'b1; axi.arready = 1'b1;
    tick; tick;
    axi.arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        axi.rvalid = 1'b0; axi.rlast = 1'b1; axi.rresp = 2'b10;
        #1;
        n_tests++;
        if (rd_ready !== 1'b0 || rd_error !== 1'b0 || rd_last !== 1'b0) begin
          n_fail++;
          $display("FAIL rlast_bubble: got rdy=%b err=%b last=%b expected 0 0 0",
                   rd_ready, rd_error, rd_last);
        end
        tick;
      end
      axi.rvalid = 1'b1; axi.rdata = 64'hA0 + 64'(i); axi.rlast = (i == 4); axi.rresp = 2'b00;
      exp_err = (i == 4) || (i == 7);
      exp_last = (i == 7);
      #1;
      n_tests++;
      if (rd_ready !== 1'b1 || rd_error !== exp_err || rd_last !== exp_last) begin
        n_fail++;
        $display("FAIL rlast_beat%0d: got rdy=%b err=%b last=%b expected 1 %b %b",
                 i, rd_ready, rd_error, rd_last, exp_err, exp_last);
      end
      tick;
    end
    slave_idle(); rd_req = 1'b0;
    #1;
    n_tests++;
    if (axi.rready !== 1'b0) begin
      n_fail++;
      $display("FAIL rlast_done: got rready=%b expected 0", axi.rready);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int n_rdy, last_at, n_err, n_dbad;
    addr = 32'h8000_0100; rd_req = 1'b1; axi.arready = 1'b1;
    tick; tick;
    for (int i = 0; i < 3; i++) begin
      axi.rvalid = 1'b1; axi.rdata = 64'(i); axi.rlast = 1'b0;
      tick;
    end
    axi.rdata = 64'h3; rst = 1'b1; rd_req = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0 ||
        rd_ready !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rdata: got valids=%b rd_ready=%b wr_ready=%b expected 00000 0 0",
               {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, rd_ready, wr_ready);
    end
    slave_idle();
    tick;
    drive_read(32'h8000_0200, 8, 64'h100, n_rdy, last_at, n_err, n_dbad);
    n_tests++;
    if (n_rdy !== 8 || last_at !== 7 || n_err !== 0 || n_dbad !== 0) begin
      n_fail++;
      $display("FAIL rst_rdata_fresh: got pulses=%0d last_at=%0d errs=%0d bad=%0d expected 8 7 0 0",
               n_rdy, last_at, n_err, n_dbad);
    end
    tick;
    addr = 32'h8000_3000; wr_data = '0; wr_req = 1'b1; axi.wready = 1'b1;
    tick; tick;
    rst = 1'b1; wr_req = 1'b0; axi.wready = 1'b0;
    tick;
    rst = 1'b0; axi.bvalid = 1'b1; axi.rvalid = 1'b1;
    #1;
    n_tests++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0 ||
        rd_ready !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_write: got valids=%b rd_ready=%b wr_ready=%b expected 00000 0 0",
               {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, rd_ready, wr_ready);
    end
    slave_idle();
    tick;
    drive_read(32'h8000_0300, 8, 64'h300, n_rdy, last_at, n_err, n_dbad);
    n_tests++;
    if (n_rdy !== 8 || last_at !== 7 || n_err !== 0 || n_dbad !== 0) begin
      n_fail++;
      $display("FAIL rst_write_fresh: got pulses=%0d last_at=%0d errs=%0d bad=%0d expected 8 7 0 0",
               n_rdy, last_at, n_err, n_dbad);
    end
  endtask

  initial begin
    test_reset();
    test_cached_read();
    test_uncached_read();
    test_back_to_back();
    test_uncached_write();
    test_rlast_mismatch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
